// File: rtl/saph_pixel_unpacker.sv
// saph_pixel_unpacker: decodes a stream of 32-bit packed pixel words into
// 32-bit ARGB colors, as described by a runtime pixfmt descriptor.
//
// Pixels are packed LSB-first and may straddle word boundaries. Each channel
// is widened to 8 bits by bit replication.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fmt_load, fmt       latch descriptor {cat,size,a,r,g,b}, flush, enter RUN
//   stop                flush buffered bits, enter IDLE
//   in_valid/in_ready   input word handshake, in_data = packed word
//   out_valid/out_ready output pixel handshake, out_col = {a,r,g,b}
//   pix_count           output handshake counter (SAPH_UNPACK_COUNT_EN only)
//
// Optional feature macro: SAPH_UNPACK_COUNT_EN adds the pix_count port.
module saph_pixel_unpacker #(
   parameter int unsigned WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fmt_load,
   input  logic [40:0]       fmt,
   input  logic              stop,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_col
`ifdef SAPH_UNPACK_COUNT_EN
   ,
   output logic [15:0]       pix_count
`endif
);

   localparam int unsigned BUF_W = 2 * WORD_W;
   localparam int unsigned CNT_W = 7;

   typedef struct packed {
      logic [4:0] pos;
      logic [2:0] width;
   } chfmt_t;

   typedef struct packed {
      logic [3:0] cat;
      logic [4:0] size;
      chfmt_t     a;
      chfmt_t     r;
      chfmt_t     g;
      chfmt_t     b;
   } pixfmt_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   if (WORD_W != 32) begin : g_word_w_check
      $error("saph_pixel_unpacker supports only WORD_W == 32");
   end

   state_t           state_q;
   logic [BUF_W-1:0] pix_buf_q;
   logic [CNT_W-1:0] cnt_q;
   pixfmt_t          fmt_q;

   logic [5:0]       psize;
   logic             run;
   logic             push;
   logic             pop;
   logic [BUF_W-1:0] buf_pop;
   logic [BUF_W-1:0] buf_nxt;
   logic [CNT_W-1:0] cnt_pop;
   logic [CNT_W-1:0] cnt_nxt;
   logic [31:0]      pix_mask;
   logic [31:0]      pix;
   logic             unused_cat;

   // cat is carried with the descriptor but has no effect on decoding
   assign unused_cat = ^fmt_q.cat;

   assign psize     = 6'(fmt_q.size) + 6'd1;
   assign run       = (state_q == ST_RUN);
   assign in_ready  = run && (cnt_q <= 7'd32);
   assign out_valid = run && (cnt_q >= 7'(psize));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Pop first, then append the new word above the surviving bits
   always_comb begin
      buf_pop = pix_buf_q;
      cnt_pop = cnt_q;
      if (pop) begin
         buf_pop = pix_buf_q >> psize;
         cnt_pop = cnt_q - 7'(psize);
      end
      buf_nxt = buf_pop;
      cnt_nxt = cnt_pop;
      if (push) begin
         buf_nxt = buf_pop | (BUF_W'(in_data) << cnt_pop);
         cnt_nxt = cnt_pop + 7'd32;
      end
   end

   // State, bit buffer and descriptor; fmt_load has priority over stop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pix_buf_q <= '0;
         cnt_q     <= '0;
         fmt_q     <= '0;
      end else if (fmt_load) begin
         state_q   <= ST_RUN;
         fmt_q     <= pixfmt_t'(fmt);
         pix_buf_q <= '0;
         cnt_q     <= '0;
      end else if (stop) begin
         state_q   <= ST_IDLE;
         pix_buf_q <= '0;
         cnt_q     <= '0;
      end else if (run) begin
         pix_buf_q <= buf_nxt;
         cnt_q     <= cnt_nxt;
      end
   end

   // Extract one channel and widen it to 8 bits by repeating it MSB-first
   function automatic logic [7:0] expand(input logic [31:0] p, input chfmt_t c,
                                         input logic [5:0] ps, input logic is_alpha);
      logic [7:0] field;
      logic [7:0] res;
      logic [3:0] wp1;
      logic [2:0] idx;
      wp1   = 4'(c.width) + 4'd1;
      field = 8'(p >> c.pos) & 8'((9'd1 << wp1) - 9'd1);
      res   = '0;
      for (int i = 0; i < 8; i++) begin
         idx        = 3'(int'(c.width) - (i % int'(wp1)));
         res[7 - i] = field[idx];
      end
      if (6'(c.pos) >= ps) begin
         res = is_alpha ? 8'hFF : 8'h00;
      end
      return res;
   endfunction

   // psize = 32 yields an all-ones mask
   assign pix_mask = 32'((64'd1 << psize) - 64'd1);
   assign pix      = pix_buf_q[31:0] & pix_mask;
   assign out_col  = {expand(pix, fmt_q.a, psize, 1'b1),
                      expand(pix, fmt_q.r, psize, 1'b0),
                      expand(pix, fmt_q.g, psize, 1'b0),
                      expand(pix, fmt_q.b, psize, 1'b0)};

`ifdef SAPH_UNPACK_COUNT_EN
   // Output handshake counter, survives stop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_count <= '0;
      end else if (fmt_load) begin
         pix_count <= '0;
      end else if (pop) begin
         pix_count <= pix_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_saph_pixel_unpacker.sv
// Directed testbench for saph_pixel_unpacker.
module tb_saph_pixel_unpacker;

   logic        clk;
   logic        rst_n;
   logic        fmt_load;
   logic [40:0] fmt;
   logic        stop;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_col;
`ifdef SAPH_UNPACK_COUNT_EN
   logic [15:0] pix_count;
`endif

   int passed = 0;
   int total  = 0;

   saph_pixel_unpacker #(.WORD_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fmt_load  (fmt_load),
      .fmt       (fmt),
      .stop      (stop),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col)
`ifdef SAPH_UNPACK_COUNT_EN
      ,
      .pix_count (pix_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [40:0] mkfmt(input logic [4:0] size,
                                         input logic [4:0] ap, input logic [2:0] aw,
                                         input logic [4:0] rp, input logic [2:0] rw,
                                         input logic [4:0] gp, input logic [2:0] gw,
                                         input logic [4:0] bp, input logic [2:0] bw);
      return {4'h5, size, ap, aw, rp, rw, gp, gw, bp, bw};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load(input logic [40:0] f);
      fmt      = f;
      fmt_load = 1'b1;
      step();
      fmt_load = 1'b0;
   endtask

   task automatic push(input logic [31:0] w, input string tag);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk(32'(in_ready), 32'd1, {tag, "_in_ready"});
      step();
      in_valid = 1'b0;
   endtask

   task automatic get_pix(input logic [31:0] exp, input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      chk(32'(out_valid), 32'd1, {tag, "_valid"});
      chk(out_col, exp, tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   logic [40:0] f565, f888, f1555;
   int          acc;
   logic        seen, stable;
   logic [31:0] first_col;

   initial begin
      f565  = mkfmt(5'd15, 5'd16, 3'd0, 5'd11, 3'd4, 5'd5, 3'd5, 5'd0, 3'd4);
      f888  = mkfmt(5'd23, 5'd24, 3'd0, 5'd16, 3'd7, 5'd8, 3'd7, 5'd0, 3'd7);
      f1555 = mkfmt(5'd15, 5'd15, 3'd0, 5'd10, 3'd4, 5'd5, 3'd4, 5'd0, 3'd4);

      rst_n = 1'b0; fmt_load = 1'b0; fmt = '0; stop = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk(32'(in_ready),  32'd0, "rst_in_ready");
      chk(32'(out_valid), 32'd0, "rst_out_valid");
      chk(out_col,        32'd0, "rst_out_col");
      step();
      rst_n = 1'b1;
      step();
      chk(32'(in_ready), 32'd0, "idle_in_ready");

      // RGB565: two pixels from one word, first visible right after accept
      load(f565);
      chk(32'(in_ready), 32'd1, "565_ready_after_load");
      push(32'hF800_07E0, "565_w0");
      chk(32'(out_valid), 32'd1, "565_latency");
      get_pix(32'hFF00FF00, "565_p0");
      get_pix(32'hFFFF0000, "565_p1");
      chk(32'(in_ready), 32'd1, "565_in_ready_stays");
      chk(32'(out_valid), 32'd0, "565_drained");

      // RGB888: 4 pixels from 3 words with straddles
      load(f888);
      push(32'h3322_1100, "888_w0");
      get_pix(32'hFF221100, "888_p0");
      push(32'h7766_5544, "888_w1");
      get_pix(32'hFF554433, "888_p1");
      push(32'hBBAA_9988, "888_w2");
      get_pix(32'hFF887766, "888_p2");
      get_pix(32'hFFBBAA99, "888_p3");

      // ARGB1555
      load(f1555);
      push(32'h0000_8210, "1555_w0");
      get_pix(32'hFF008484, "1555_p0");
      get_pix(32'h00000000, "1555_p1");

      // Backpressure: only two words fit, head pixel held stable
      load(f565);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      acc = 0; seen = 1'b0; stable = 1'b1; first_col = '0;
      for (int c = 0; c < 10; c++) begin
         in_data = (acc == 0) ? 32'hF800_07E0 : 32'h001F_FFFF;
         if (in_ready) acc++;
         step();
         if (out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               first_col = out_col;
            end else if (out_col !== first_col) begin
               stable = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk(32'(acc),       32'd2, "bp_words_accepted");
      chk(32'(in_ready),  32'd0, "bp_in_ready_full");
      chk(32'(stable),    32'd1, "bp_out_col_stable");
      get_pix(32'hFF00FF00, "bp_p0");
      get_pix(32'hFFFF0000, "bp_p1");
      get_pix(32'hFFFFFFFF, "bp_p2");
      get_pix(32'hFF0000FF, "bp_p3");

      // fmt_load mid-stream discards the 8 residual bits
      load(f888);
      push(32'h3322_1100, "ml_w0");
      get_pix(32'hFF221100, "ml_p0");
      chk(32'(out_valid), 32'd0, "ml_residual_not_valid");
      load(f565);
      chk(32'(out_valid), 32'd0, "ml_flushed");
      push(32'h001F_F800, "ml_w1");
      get_pix(32'hFFFF0000, "ml_p1");
      get_pix(32'hFF0000FF, "ml_p2");

      // stop returns to IDLE
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk(32'(in_ready), 32'd0, "stop_in_ready");

      // Asynchronous reset while a pixel is pending
      load(f565);
      push(32'hF800_07E0, "ar_w0");
      chk(32'(out_valid), 32'd1, "ar_pending");
      #3;
      rst_n = 1'b0;
      #1;
      chk(32'(out_valid), 32'd0, "ar_out_valid_async");
      chk(32'(in_ready),  32'd0, "ar_in_ready_async");
      chk(out_col,        32'd0, "ar_out_col");
`ifdef SAPH_UNPACK_COUNT_EN
      chk(32'(pix_count), 32'd0, "ar_pix_count");
`endif
      step();
      rst_n = 1'b1;
      step();
      chk(32'(out_valid), 32'd0, "ar_idle_out_valid");
      chk(32'(in_ready),  32'd0, "ar_idle_in_ready");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
